// File: rtl/serial_byte_collector_pkg.sv
// Shared constants for the serial byte collector and its downstream parallel register.
// cw_of() sizes the bit counter for a given word width.
package serial_byte_collector_pkg;

  localparam int DEFAULT_WIDTH = 8;

  function automatic int cw_of(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/serial_byte_collector_if.sv
// Serial-in / word-out bundle between the bit source, the collector and the word consumer.
interface serial_byte_collector_if #(
  parameter int WIDTH = serial_byte_collector_pkg::DEFAULT_WIDTH,
  parameter int CW    = serial_byte_collector_pkg::cw_of(WIDTH)
);

  logic             serial_in;
  logic             bit_valid;
  logic             clear;
  logic             byte_ack;
  logic [WIDTH-1:0] byte_out;
  logic             byte_ready;
  logic             overrun;
  logic [CW-1:0]    bit_count;

  modport master (
    output serial_in, bit_valid, clear, byte_ack,
    input  byte_out, byte_ready, overrun, bit_count
  );

  modport slave (
    input  serial_in, bit_valid, clear, byte_ack,
    output byte_out, byte_ready, overrun, bit_count
  );

endinterface

// File: rtl/serial_byte_collector_bit_counter.sv
// Mod-WIDTH bit counter with increment, synchronous clear and terminal-count flag.
module bit_counter
  import serial_byte_collector_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  localparam int CW   = cw_of(WIDTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc,
  input  logic          clr,
  output logic [CW-1:0] count,
  output logic          tc
);

  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [CW-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count_reg <= '0;
    end else if (inc) begin
      count_reg <= (count_reg == LAST) ? '0 : count_reg + 1'b1;
    end
  end

  assign count = count_reg;
  assign tc    = (count_reg == LAST);

endmodule

// File: rtl/serial_byte_collector.sv
// Assembles a qualified serial bit stream into WIDTH-bit words with a ready/ack handshake
// and a sticky overrun flag for words overwritten before being acknowledged.
module serial_byte_collector
  import serial_byte_collector_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit MSB_FIRST = 1'b1,
  localparam int CW       = cw_of(WIDTH)
) (
  input logic                    clk,
  input logic                    rst,
  serial_byte_collector_if.slave bus
);

  logic [WIDTH-1:0] shreg_reg;
  logic [WIDTH-1:0] shreg_next;
  logic [WIDTH-1:0] byte_out_reg;
  logic             byte_ready_reg;
  logic             overrun_reg;
  logic [CW-1:0]    count;
  logic             tc;
  logic             shift;
  logic             complete;

  // A bit arriving together with clear is dropped, so clear also gates the shift.
  assign shift    = bus.bit_valid && !bus.clear;
  assign complete = shift && tc;

  if (MSB_FIRST) begin : g_msb_first
    assign shreg_next = {shreg_reg[WIDTH-2:0], bus.serial_in};
  end else begin : g_lsb_first
    assign shreg_next = {bus.serial_in, shreg_reg[WIDTH-1:1]};
  end

  bit_counter #(.WIDTH(WIDTH)) u_bit_counter (
    .clk   (clk),
    .rst   (rst),
    .inc   (shift),
    .clr   (bus.clear),
    .count (count),
    .tc    (tc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      shreg_reg      <= '0;
      byte_out_reg   <= '0;
      byte_ready_reg <= 1'b0;
      overrun_reg    <= 1'b0;
    end else if (bus.clear) begin
      shreg_reg      <= '0;
      byte_ready_reg <= 1'b0;
      overrun_reg    <= 1'b0;
    end else begin
      if (shift) begin
        shreg_reg <= shreg_next;
      end
      if (complete) begin
        byte_out_reg   <= shreg_next;
        byte_ready_reg <= 1'b1;
        // An ack landing in the completion cycle consumed the old word, so no loss.
        if (byte_ready_reg && !bus.byte_ack) begin
          overrun_reg <= 1'b1;
        end
      end else if (bus.byte_ack) begin
        byte_ready_reg <= 1'b0;
      end
    end
  end

  assign bus.byte_out   = byte_out_reg;
  assign bus.byte_ready = byte_ready_reg;
  assign bus.overrun    = overrun_reg;
  assign bus.bit_count  = count;

endmodule

// File: tb/tb_serial_byte_collector.sv
// Directed bench driving an MSB-first and an LSB-first collector from one shared bit stream.
module tb_serial_byte_collector;

  logic clk = 1'b0;
  logic rst;
  logic si;
  logic bv;
  logic clr;
  logic ack;

  int total = 0;
  int bad   = 0;

  logic [7:0] q_m[$];
  logic [7:0] q_l[$];

  always #5 clk = ~clk;

  serial_byte_collector_if #(.WIDTH(8)) bus_m ();
  serial_byte_collector_if #(.WIDTH(8)) bus_l ();

  assign bus_m.serial_in = si;
  assign bus_m.bit_valid = bv;
  assign bus_m.clear     = clr;
  assign bus_m.byte_ack  = ack;
  assign bus_l.serial_in = si;
  assign bus_l.bit_valid = bv;
  assign bus_l.clear     = clr;
  assign bus_l.byte_ack  = ack;

  serial_byte_collector #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_m (
    .clk (clk),
    .rst (rst),
    .bus (bus_m)
  );

  serial_byte_collector #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (
    .clk (clk),
    .rst (rst),
    .bus (bus_l)
  );

  // Bits are sent first-to-last as w[7]..w[0]; an LSB-first collector sees the mirror image.
  function automatic logic [7:0] rev8(input logic [7:0] w);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = w[7-i];
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_cnt(input string tag, input int exp);
    chk({tag, "_m"}, 32'(bus_m.bit_count), 32'(exp));
    chk({tag, "_l"}, 32'(bus_l.bit_count), 32'(exp));
  endtask

  task automatic chk_flags(input string tag, input logic rdy, input logic ovr);
    chk({tag, "_rdy_m"}, 32'(bus_m.byte_ready), 32'(rdy));
    chk({tag, "_rdy_l"}, 32'(bus_l.byte_ready), 32'(rdy));
    chk({tag, "_ovr_m"}, 32'(bus_m.overrun), 32'(ovr));
    chk({tag, "_ovr_l"}, 32'(bus_l.overrun), 32'(ovr));
  endtask

  task automatic pop_check(input string tag);
    if (q_m.size() == 0 || q_l.size() == 0) begin
      total++;
      bad++;
      $error("FAIL %s: observed=empty_queue expected=word", tag);
    end else begin
      chk({tag, "_out_m"}, 32'(bus_m.byte_out), 32'(q_m.pop_front()));
      chk({tag, "_out_l"}, 32'(bus_l.byte_out), 32'(q_l.pop_front()));
    end
  endtask

  task automatic send_word(input logic [7:0] w, input int max_gap, input bit ack_last,
                           input bit check_count);
    for (int i = 0; i < 8; i++) begin
      int gap;
      gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
      repeat (gap) begin
        bv = 1'b0;
        tick();
        if (check_count) chk_cnt("cnt_gap", i);
      end
      si = w[7-i];
      bv = 1'b1;
      if (i == 7) begin
        ack = ack_last;
        q_m.push_back(w);
        q_l.push_back(rev8(w));
      end
      tick();
      if (check_count) chk_cnt("cnt", (i + 1) % 8);
    end
    bv  = 1'b0;
    ack = 1'b0;
  endtask

  task automatic pulse_ack();
    ack = 1'b1;
    tick();
    ack = 1'b0;
  endtask

  initial begin
    si  = 1'b0;
    bv  = 1'b0;
    clr = 1'b0;
    ack = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    chk("rst_out_m", 32'(bus_m.byte_out), 32'h00);
    chk("rst_out_l", 32'(bus_l.byte_out), 32'h00);
    chk_flags("rst", 1'b0, 1'b0);
    chk_cnt("rst_cnt", 0);
    rst = 1'b0;

    // Consecutive bits, then ack.
    send_word(8'hA5, 0, 1'b0, 1'b1);
    pop_check("a5_b2b");
    chk_flags("a5_b2b", 1'b1, 1'b0);
    pulse_ack();
    chk_flags("a5_ack", 1'b0, 1'b0);
    pulse_ack();
    chk_flags("idle_ack", 1'b0, 1'b0);

    // Random gaps between bits; count must advance only on valid bits.
    send_word(8'hA5, 3, 1'b0, 1'b1);
    pop_check("a5_gap");
    chk_flags("a5_gap", 1'b1, 1'b0);
    pulse_ack();
    send_word(8'h1E, 2, 1'b0, 1'b1);
    pop_check("1e_gap");
    chk_flags("1e_gap", 1'b1, 1'b0);
    pulse_ack();

    // Overrun: second word completes while the first is still unacked.
    send_word(8'h3C, 0, 1'b0, 1'b0);
    pop_check("3c");
    chk_flags("3c", 1'b1, 1'b0);
    send_word(8'hC3, 0, 1'b0, 1'b0);
    pop_check("c3");
    chk_flags("c3_ovr", 1'b1, 1'b1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk_flags("clear", 1'b0, 1'b0);
    chk("clear_hold_m", 32'(bus_m.byte_out), 32'hC3);
    chk("clear_hold_l", 32'(bus_l.byte_out), 32'hC3);
    chk_cnt("clear_cnt", 0);

    // Partial word aborted by clear; the bit presented alongside clear is dropped.
    si = 1'b1;
    bv = 1'b1;
    repeat (3) tick();
    chk_cnt("partial_cnt", 3);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    bv  = 1'b0;
    chk_cnt("clr_drop_cnt", 0);
    send_word(8'h1E, 0, 1'b0, 1'b1);
    pop_check("after_clr");
    chk_flags("after_clr", 1'b1, 1'b0);
    pulse_ack();

    // Ack coinciding with completion of the next word: no overrun, ready stays high.
    send_word(8'h5A, 0, 1'b0, 1'b0);
    pop_check("5a");
    chk_flags("5a", 1'b1, 1'b0);
    send_word(8'h96, 1, 1'b1, 1'b0);
    pop_check("96_ack_same");
    chk_flags("96_ack_same", 1'b1, 1'b0);
    pulse_ack();
    chk_flags("96_acked", 1'b0, 1'b0);

    // Reset mid-word, then a full word must assemble with no stale bits.
    si = 1'b0;
    bv = 1'b1;
    repeat (5) tick();
    chk_cnt("mid_cnt", 5);
    rst = 1'b1;
    bv  = 1'b0;
    tick();
    rst = 1'b0;
    chk_cnt("mid_rst_cnt", 0);
    chk("mid_rst_out_m", 32'(bus_m.byte_out), 32'h00);
    chk("mid_rst_out_l", 32'(bus_l.byte_out), 32'h00);
    chk_flags("mid_rst", 1'b0, 1'b0);
    send_word(8'hFF, 0, 1'b0, 1'b1);
    pop_check("ff");
    chk_flags("ff", 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
